// File: rtl/mem_ctrl.sv
// Arbitrating controller: instruction fetch and data load/store ports share one byte-wide memory.
// Define MEM_CTRL_SKIP_EN to make stores issue only the byte lanes enabled in mem_sel.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        bus_en,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        stallreq
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_tail, w_tail_nxt;
  logic        r_is_mem;
  logic        r_we;
  logic [29:0] r_word;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic        r_cap_valid;
  logic [1:0]  r_cap_idx;
  logic [23:0] r_rbuf;
  logic [31:0] r_if_data, r_mem_rdata;
  logic        w_bus_en;
  logic [31:0] w_rd_word;
  logic        w_unused;

`ifdef MEM_CTRL_SKIP_EN
  logic [2:0]  w_nb;

  // Returns {found, lane} for the lowest enabled lane at or above start.
  function automatic logic [2:0] f_next_byte(input logic [3:0] sel, input logic [2:0] start);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (k[2:0] >= start && sel[k]) res = {1'b1, k[1:0]};
    end
    return res;
  endfunction
`endif

  // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tail_nxt  = r_tail;
`ifdef MEM_CTRL_SKIP_EN
    w_nb        = 3'b000;
`endif
    case (r_state)
      IDLE: begin
        if (mem_req || if_req) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = 2'd0;
          w_tail_nxt  = 1'b0;
`ifdef MEM_CTRL_SKIP_EN
          if (mem_req && mem_we) begin
            w_nb = f_next_byte(mem_sel, 3'd0);
            if (w_nb[2]) w_cnt_nxt   = w_nb[1:0];
            else         w_state_nxt = DONE;
          end
`endif
        end
      end
      BUSY: begin
        if (r_tail) begin
          w_state_nxt = DONE;
        end else if (r_we) begin
`ifdef MEM_CTRL_SKIP_EN
          w_nb = f_next_byte(r_sel, {1'b0, r_cnt} + 3'd1);
          if (w_nb[2]) w_cnt_nxt   = w_nb[1:0];
          else         w_state_nxt = DONE;
`else
          if (r_cnt == 2'd3) w_state_nxt = DONE;
          else               w_cnt_nxt   = r_cnt + 2'd1;
`endif
        end else begin
          // Reads need one extra cycle so the last byte can come back from the bus.
          if (r_cnt == 2'd3) w_tail_nxt = 1'b1;
          else               w_cnt_nxt  = r_cnt + 2'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rd_word = {bus_rdata, r_rbuf};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_tail      <= 1'b0;
      r_is_mem    <= 1'b0;
      r_we        <= 1'b0;
      r_word      <= '0;
      r_sel       <= '0;
      r_wdata     <= '0;
      r_cap_valid <= 1'b0;
      r_cap_idx   <= 2'd0;
      r_rbuf      <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tail      <= w_tail_nxt;
      r_cap_valid <= w_bus_en & ~r_we;
      r_cap_idx   <= r_cnt;

      if (r_cap_valid) begin
        case (r_cap_idx)
          2'd0:    r_rbuf[7:0]   <= bus_rdata;
          2'd1:    r_rbuf[15:8]  <= bus_rdata;
          2'd2:    r_rbuf[23:16] <= bus_rdata;
          default: ;
        endcase
      end

      if (r_state == IDLE) begin
        if (mem_req) begin
          r_is_mem <= 1'b1;
          r_we     <= mem_we;
          r_word   <= mem_addr[31:2];
          r_sel    <= mem_sel;
          r_wdata  <= mem_wdata;
        end else if (if_req) begin
          r_is_mem <= 1'b0;
          r_we     <= 1'b0;
          r_word   <= if_addr[31:2];
          r_sel    <= 4'hF;
          r_wdata  <= '0;
        end
      end

      if (r_state == BUSY && w_state_nxt == DONE && !r_we) begin
        if (r_is_mem) r_mem_rdata <= w_rd_word;
        else          r_if_data   <= w_rd_word;
      end
    end
  end

  assign w_bus_en  = (r_state == BUSY) && !r_tail;
  assign bus_en    = w_bus_en;
  assign bus_wr    = w_bus_en && r_we && r_sel[r_cnt];
  assign bus_addr  = w_bus_en ? {r_word, r_cnt} : 32'd0;
  assign bus_wdata = (w_bus_en && r_we) ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'd0;

  assign if_done   = (r_state == DONE) && !r_is_mem;
  assign mem_done  = (r_state == DONE) &&  r_is_mem;
  assign if_data   = r_if_data;
  assign mem_rdata = r_mem_rdata;

  assign stallreq  = (if_req & ~if_done) | (mem_req & ~mem_done);

  // Low address bits are deliberately ignored: all accesses are word aligned.
  assign w_unused  = ^{if_addr[1:0], mem_addr[1:0]};

endmodule
